// File: rtl/minhash_pkg.sv
// Shared types for the bottom-S MinHash sketch: hash word, sequencer states, all-ones sentinel.
package minhash_pkg;

    localparam int HASH_W_DEF = 32;

    typedef logic [HASH_W_DEF-1:0] hash_t;

    typedef enum logic [1:0] {
        SK_IDLE,
        SK_ACCUM,
        SK_EMIT
    } sk_state_e;

    localparam hash_t HASH_MAX = '1;

endpackage

// File: rtl/bottom_s_sketch_if.sv
// Hash-in / sketch-out bundle between the murmur stage, the sketch unit and the signature stage.
interface bottom_s_sketch_if #(
    parameter int HASH_W = 32,
    parameter int S      = 8,
    parameter int CNT_W  = 16
);
    localparam int CW = $clog2(S + 1);

    logic                       start;
    logic                       in_valid;
    logic                       in_ready;
    logic [HASH_W-1:0]          in_hash;
    logic                       in_last;
    logic                       sk_valid;
    logic                       sk_ready;
    logic [S-1:0][HASH_W-1:0]   sk_vals;
    logic [CW-1:0]              sk_count;
    logic [CNT_W-1:0]           n_seen;
    logic                       busy;

    modport slave (
        input  start, in_valid, in_hash, in_last, sk_ready,
        output in_ready, sk_valid, sk_vals, sk_count, n_seen, busy
    );

    modport master (
        output start, in_valid, in_hash, in_last, sk_ready,
        input  in_ready, sk_valid, sk_vals, sk_count, n_seen, busy
    );
endinterface

// File: rtl/sketch_slot.sv
// One sketch entry: held value/valid plus its compare against the incoming hash.
// An empty slot compares as "greater than anything", so it always accepts an insert.
module sketch_slot #(
    parameter int HASH_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic [HASH_W-1:0] i_v,
    input  logic [HASH_W-1:0] i_left_val,
    input  logic              i_left_valid,
    input  logic              i_shift,
    input  logic              i_write,
    output logic              o_lt,
    output logic              o_eq,
    output logic [HASH_W-1:0] o_val,
    output logic              o_valid
);

    logic [HASH_W-1:0] r_val;
    logic              r_valid;

    always_ff @(posedge clk) begin
        if (!reset_n || i_clear) begin
            r_val   <= '1;
            r_valid <= 1'b0;
        end else if (i_write) begin
            r_val   <= i_v;
            r_valid <= 1'b1;
        end else if (i_shift) begin
            r_val   <= i_left_val;
            r_valid <= i_left_valid;
        end
    end

    assign o_lt    = !r_valid || (i_v < r_val);
    assign o_eq    = r_valid && (i_v == r_val);
    assign o_val   = r_val;
    assign o_valid = r_valid;

endmodule

// File: rtl/bottom_s_sketch.sv
// Streaming bottom-S MinHash sketch: inserts one hash per clock into a sorted slot chain
// and presents the S smallest values at the end of each window.
//
//  state    | meaning
//  SK_IDLE  | waiting for start; last sketch left on the outputs
//  SK_ACCUM | accepting hashes, one full insert per clock
//  SK_EMIT  | sketch presented, held until the consumer takes it
module bottom_s_sketch
    import minhash_pkg::*;
#(
    parameter int HASH_W = 32,
    parameter int S      = 8,
    parameter int DEDUP  = 1,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    bottom_s_sketch_if.slave   sk
);

    localparam int CW = $clog2(S + 1);
    localparam int PW = (S > 1) ? $clog2(S) : 1;

    sk_state_e r_state, w_next;

    logic [S-1:0]              w_lt, w_eq, w_valid, w_write, w_shift;
    logic [S-1:0][HASH_W-1:0]  w_vals;
    logic [PW-1:0]             w_p;
    logic                      w_accept, w_clear, w_insert, w_drop_dup;
    logic                      w_in_ready, w_sk_valid, w_busy;
    logic [CW-1:0]             r_count;
    logic [CNT_W-1:0]          r_nseen;

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= SK_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            SK_IDLE:  if (sk.start)               w_next = SK_ACCUM;
            SK_ACCUM: if (w_accept && sk.in_last) w_next = SK_EMIT;
            SK_EMIT:  if (sk.sk_ready)            w_next = SK_IDLE;
            default:                              w_next = SK_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_sk_valid = 1'b0;
        w_busy     = 1'b1;
        case (r_state)
            SK_IDLE:  w_busy     = 1'b0;
            SK_ACCUM: w_in_ready = 1'b1;
            SK_EMIT:  w_sk_valid = 1'b1;
            default:  w_busy     = 1'b0;
        endcase
    end

    assign w_accept   = sk.in_valid && w_in_ready;
    assign w_clear    = (r_state == SK_IDLE) && sk.start;
    assign w_drop_dup = (DEDUP != 0) && (|w_eq);
    assign w_insert   = w_accept && !w_drop_dup && (|w_lt);

    // Lowest slot that the new value belongs in; meaningful only when |w_lt.
    always_comb begin
        w_p = '0;
        for (int i = S - 1; i >= 0; i--) begin
            if (w_lt[i]) w_p = PW'(i);
        end
    end

    always_comb begin
        w_write = '0;
        w_shift = '0;
        for (int i = 0; i < S; i++) begin
            w_write[i] = w_insert && (PW'(i) == w_p);
            w_shift[i] = w_insert && (PW'(i) >  w_p);
        end
    end

    for (genvar g = 0; g < S; g++) begin : g_slot
        logic [HASH_W-1:0] w_left_val;
        logic              w_left_valid;
        if (g == 0) begin : g_first
            assign w_left_val   = '1;
            assign w_left_valid = 1'b0;
        end else begin : g_rest
            assign w_left_val   = w_vals[g-1];
            assign w_left_valid = w_valid[g-1];
        end
        sketch_slot #(.HASH_W(HASH_W)) u_slot (
            .clk          (clk),
            .reset_n      (reset_n),
            .i_clear      (w_clear),
            .i_v          (sk.in_hash),
            .i_left_val   (w_left_val),
            .i_left_valid (w_left_valid),
            .i_shift      (w_shift[g]),
            .i_write      (w_write[g]),
            .o_lt         (w_lt[g]),
            .o_eq         (w_eq[g]),
            .o_val        (w_vals[g]),
            .o_valid      (w_valid[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n || w_clear) begin
            r_count <= '0;
            r_nseen <= '0;
        end else begin
            if (w_insert && (r_count != CW'(S))) r_count <= r_count + 1'b1;
            if (w_accept && (r_nseen != '1))     r_nseen <= r_nseen + 1'b1;
        end
    end

    assign sk.in_ready = w_in_ready;
    assign sk.sk_valid = w_sk_valid;
    assign sk.busy     = w_busy;
    assign sk.sk_vals  = w_vals;
    assign sk.sk_count = r_count;
    assign sk.n_seen   = r_nseen;

endmodule

// File: tb/tb_bottom_s_sketch.sv
// Scoreboard bench: two S=4, CNT_W=4 instances (dedup on/off) fed the same hash windows.
module tb_bottom_s_sketch;
    import minhash_pkg::*;

    typedef struct {
        logic [3:0][31:0] vals;
        int               count;
        int               nseen;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0, in_valid = 1'b0, in_last = 1'b0, sk_ready = 1'b0;
    logic [31:0] in_hash = '0;

    int total = 0;
    int bad = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ma, mb;

    always #5 clk = ~clk;

    bottom_s_sketch_if #(.HASH_W(32), .S(4), .CNT_W(4)) ifa ();
    bottom_s_sketch_if #(.HASH_W(32), .S(4), .CNT_W(4)) ifb ();

    assign ifa.start = start;    assign ifb.start = start;
    assign ifa.in_valid = in_valid; assign ifb.in_valid = in_valid;
    assign ifa.in_hash = in_hash;  assign ifb.in_hash = in_hash;
    assign ifa.in_last = in_last;  assign ifb.in_last = in_last;
    assign ifa.sk_ready = sk_ready; assign ifb.sk_ready = sk_ready;

    bottom_s_sketch #(.HASH_W(32), .S(4), .DEDUP(1), .CNT_W(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .sk(ifa.slave));
    bottom_s_sketch #(.HASH_W(32), .S(4), .DEDUP(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .sk(ifb.slave));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: sort the whole window, optionally make it unique, keep the first four.
    function automatic exp_t model(input logic [31:0] hs[$], input bit dedup);
        exp_t m;
        logic [31:0] s[$];
        logic [31:0] u[$];
        s = hs;
        s.sort();
        foreach (s[i]) begin
            if (!dedup || u.size() == 0 || u[u.size()-1] != s[i]) u.push_back(s[i]);
        end
        m.count = (u.size() > 4) ? 4 : u.size();
        for (int i = 0; i < 4; i++) m.vals[i] = (i < u.size()) ? u[i] : 32'hFFFF_FFFF;
        m.nseen = (hs.size() > 15) ? 15 : hs.size();
        return m;
    endfunction

    always @(negedge clk) begin
        if (reset_n && ifa.sk_valid && ifa.sk_ready) begin
            if (exp_a.size() == 0) begin
                total++; bad++;
                $display("FAIL mon_a_unexpected: got sketch expected none");
            end else begin
                ma = exp_a.pop_front();
                chk("a_vals", ifa.sk_vals, ma.vals);
                chk("a_count", ifa.sk_count, ma.count);
                chk("a_nseen", ifa.n_seen, ma.nseen);
            end
        end
        if (reset_n && ifb.sk_valid && ifb.sk_ready) begin
            if (exp_b.size() == 0) begin
                total++; bad++;
                $display("FAIL mon_b_unexpected: got sketch expected none");
            end else begin
                mb = exp_b.pop_front();
                chk("b_vals", ifb.sk_vals, mb.vals);
                chk("b_count", ifb.sk_count, mb.count);
                chk("b_nseen", ifb.n_seen, mb.nseen);
            end
        end
    end

    task automatic run_window(input logic [31:0] hs[$], input int hold, input bit gaps,
                              input bit hold_chk);
        exp_t ea, eb;
        ea = model(hs, 1'b1);
        eb = model(hs, 1'b0);
        exp_a.push_back(ea);
        exp_b.push_back(eb);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("accum_in_ready", ifa.in_ready, 1);
        foreach (hs[i]) begin
            if (gaps && $urandom_range(0, 7) == 0) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_hash  = hs[i];
            in_last  = (i == hs.size() - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("emit_latency", ifa.sk_valid, 1);
        repeat (hold) begin
            if (hold_chk) begin
                start = 1'b1;
                chk("hold_vals", ifa.sk_vals, ea.vals);
                chk("hold_count", ifa.sk_count, ea.count);
                chk("hold_nseen", ifa.n_seen, ea.nseen);
                chk("hold_in_ready", ifa.in_ready, 0);
                chk("hold_valid", ifa.sk_valid, 1);
            end
            tick();
        end
        start = 1'b0;
        sk_ready = 1'b1;
        tick();
        sk_ready = 1'b0;
        chk("idle_busy_a", ifa.busy, 0);
        chk("idle_busy_b", ifb.busy, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q[$];
        int n, mode;

        repeat (3) tick();
        chk("rst_busy", ifa.busy, 0);
        chk("rst_in_ready", ifa.in_ready, 0);
        chk("rst_sk_valid", ifa.sk_valid, 0);
        chk("rst_count", ifa.sk_count, 0);
        chk("rst_nseen", ifa.n_seen, 0);
        chk("rst_vals", ifa.sk_vals, {4{32'hFFFF_FFFF}});
        reset_n = 1'b1;
        tick();

        q.delete(); q.push_back(50); q.push_back(10); q.push_back(40);
        q.push_back(30); q.push_back(20);
        run_window(q, 0, 1'b0, 1'b0);

        q.delete(); q.push_back(7); q.push_back(7); q.push_back(3); q.push_back(7);
        run_window(q, 2, 1'b0, 1'b0);

        q.delete(); q.push_back(9); q.push_back(2); q.push_back(6);
        run_window(q, 10, 1'b0, 1'b1);
        tick();
        chk("start_ignored_busy", ifa.busy, 0);

        q.delete(); q.push_back(32'hFFFF_FFFF);
        run_window(q, 0, 1'b0, 1'b0);
        q.delete(); q.push_back(5); q.push_back(6); q.push_back(7);
        q.push_back(8); q.push_back(0);
        run_window(q, 1, 1'b0, 1'b0);
        q.delete(); q.push_back(1); q.push_back(2); q.push_back(3);
        q.push_back(4); q.push_back(9);
        run_window(q, 0, 1'b0, 1'b0);

        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_hash = 32'(100 + i); in_last = 1'b0; tick();
        end
        in_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midrst_busy", ifa.busy, 0);
        chk("midrst_count", ifa.sk_count, 0);
        chk("midrst_nseen", ifa.n_seen, 0);
        chk("midrst_vals", ifa.sk_vals, {4{32'hFFFF_FFFF}});
        q.delete(); q.push_back(500); q.push_back(600);
        run_window(q, 0, 1'b0, 1'b0);

        for (int w = 0; w < 1000; w++) begin
            q.delete();
            n = $urandom_range(1, 64);
            mode = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                case (mode)
                    0:       q.push_back(32'($urandom_range(0, 15)));
                    1:       q.push_back($urandom);
                    default: q.push_back(32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
                endcase
            end
            run_window(q, $urandom_range(0, 3), 1'b1, 1'b0);
        end

        repeat (3) tick();
        chk("drain_a", exp_a.size(), 0);
        chk("drain_b", exp_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
